// File: rtl/tone_sequencer.sv
// Square-wave note sequencer for the mono audio amplifier: plays one ROM sequence per request.
// Optional TONE_SEQ_REPEAT_EN: sound 2 loops while req is held at the end of each pass.
module tone_sequencer #(
   parameter int NOTE_TICKS = 12_500_000,
   parameter int TONE_SHIFT = 0,
   parameter int HP_W       = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [1:0] sound_id,
   output logic       busy,
   output logic       done,
   output logic       audio,
   output logic       gain,
   output logic       notshutdown
);

   localparam int NC_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
   localparam logic [NC_W-1:0] NOTE_LAST = NC_W'(NOTE_TICKS - 1);

   // Note codes double as indices into the half-period table.
   localparam logic [1:0] N_C5 = 2'd0;
   localparam logic [1:0] N_E5 = 2'd1;
   localparam logic [1:0] N_G5 = 2'd2;
   localparam logic [1:0] N_C6 = 2'd3;
   localparam int ROM_BASE [4] = '{95602, 75873, 63776, 47755};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [1:0]        id_reg, id_next;
   logic [1:0]        note_idx_reg, note_idx_next;
   logic [NC_W-1:0]   note_cnt_reg, note_cnt_next;
   logic [HP_W-1:0]   hp_cnt_reg, hp_cnt_next;
   logic              audio_reg, audio_next;

   logic [HP_W-1:0]   hp_last_tab [4];
   logic [1:0]        note_code;
   logic [1:0]        last_idx;
   logic [HP_W-1:0]   hp_last;
   logic              note_end;
   logic              last_note;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_hp
         localparam int HP_VAL = ROM_BASE[gi] >> TONE_SHIFT;
         assign hp_last_tab[gi] = HP_W'(HP_VAL - 1);
      end
   endgenerate

   // Sequence ROM: note code for the current index and the index of the final note.
   always_comb begin
      note_code = N_C5;
      last_idx  = 2'd0;
      case (id_reg)
         2'd0: begin
            last_idx  = 2'd0;
            note_code = N_C6;
         end
         2'd1: begin
            last_idx = 2'd2;
            case (note_idx_reg)
               2'd0:    note_code = N_C5;
               2'd1:    note_code = N_E5;
               default: note_code = N_G5;
            endcase
         end
         2'd2: begin
            last_idx  = 2'd3;
            note_code = note_idx_reg[0] ? N_C5 : N_G5;
         end
         default: begin
            last_idx = 2'd3;
            case (note_idx_reg)
               2'd0:    note_code = N_C5;
               2'd1:    note_code = N_E5;
               2'd2:    note_code = N_G5;
               default: note_code = N_C6;
            endcase
         end
      endcase
   end

   assign hp_last   = hp_last_tab[note_code];
   assign note_end  = (note_cnt_reg == NOTE_LAST);
   assign last_note = (note_idx_reg == last_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         id_reg       <= 2'd0;
         note_idx_reg <= 2'd0;
         note_cnt_reg <= '0;
         hp_cnt_reg   <= '0;
         audio_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         id_reg       <= id_next;
         note_idx_reg <= note_idx_next;
         note_cnt_reg <= note_cnt_next;
         hp_cnt_reg   <= hp_cnt_next;
         audio_reg    <= audio_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      id_next       = id_reg;
      note_idx_next = note_idx_reg;
      note_cnt_next = note_cnt_reg;
      hp_cnt_next   = hp_cnt_reg;
      audio_next    = audio_reg;
      busy          = 1'b0;
      done          = 1'b0;
      notshutdown   = 1'b0;
      case (state_reg)
         IDLE: begin
            audio_next = 1'b0;
            if (req) begin
               id_next       = sound_id;
               note_idx_next = 2'd0;
               note_cnt_next = '0;
               hp_cnt_next   = '0;
               state_next    = PLAY;
            end
         end
         PLAY: begin
            busy        = 1'b1;
            notshutdown = 1'b1;
            if (note_end) begin
               // Note boundary wins over a coincident half-period toggle.
               note_cnt_next = '0;
               hp_cnt_next   = '0;
               audio_next    = 1'b0;
               if (!last_note) begin
                  note_idx_next = note_idx_reg + 2'd1;
               end
`ifdef TONE_SEQ_REPEAT_EN
               else if (id_reg == 2'd2 && req) begin
                  note_idx_next = 2'd0;
               end
`endif
               else begin
                  state_next = FINISH;
               end
            end else begin
               note_cnt_next = note_cnt_reg + 1'b1;
               if (hp_cnt_reg == hp_last) begin
                  hp_cnt_next = '0;
                  audio_next  = ~audio_reg;
               end else begin
                  hp_cnt_next = hp_cnt_reg + 1'b1;
               end
            end
         end
         FINISH: begin
            busy       = 1'b1;
            done       = 1'b1;
            audio_next = 1'b0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign audio = audio_reg;
   assign gain  = 1'b1;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: per-cycle timeline model plus directed literal checks.
module tb_tone_sequencer;

   localparam int NT = 1000;

   logic       clk;
   logic       rst;
   logic       req;
   logic [1:0] sound_id;
   logic       busy;
   logic       done;
   logic       audio;
   logic       gain;
   logic       notshutdown;

   int checks = 0;
   int errors = 0;

   tone_sequencer #(
      .NOTE_TICKS(NT),
      .TONE_SHIFT(8),
      .HP_W(18)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .sound_id(sound_id),
      .busy(busy),
      .done(done),
      .audio(audio),
      .gain(gain),
      .notshutdown(notshutdown)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shifted half-periods C5, E5, G5, C6 and the note list of every sound.
   int hp_tab [4] = '{373, 296, 249, 186};
   int seq_len [4] = '{1, 3, 4, 4};
   int seq_tab [4][4] = '{'{3, 0, 0, 0}, '{0, 1, 2, 0}, '{2, 0, 2, 0}, '{0, 1, 2, 3}};

   typedef enum {M_IDLE, M_PLAY, M_FIN} mphase_t;
   mphase_t m_phase = M_IDLE;
   int      m_id = 0;
   int      m_p = 0;
   int      cyc = 0;

   // Model: m_p is the position (in cycles) inside the current pass of the sequence.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = M_IDLE;
      end else begin
         cyc++;
         case (m_phase)
            M_IDLE: if (req) begin
               m_phase = M_PLAY;
               m_id    = int'(sound_id);
               m_p     = 0;
            end
            M_PLAY: begin
               if (m_p == seq_len[m_id] * NT - 1) begin
`ifdef TONE_SEQ_REPEAT_EN
                  if (m_id == 2 && req) m_p = 0;
                  else m_phase = M_FIN;
`else
                  m_phase = M_FIN;
`endif
               end else begin
                  m_p++;
               end
            end
            default: m_phase = M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [4:0] exp_v;
      logic [4:0] act_v;
      int         hp;
      int         pos;
      act_v = {busy, done, audio, gain, notshutdown};
      case (m_phase)
         M_PLAY: begin
            hp    = hp_tab[seq_tab[m_id][m_p / NT]];
            pos   = m_p % NT;
            exp_v = {1'b1, 1'b0, ((pos / hp) % 2) == 1, 1'b1, 1'b1};
         end
         M_FIN:   exp_v = 5'b11010;
         default: exp_v = 5'b00010;
      endcase
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL cycle_model cyc=%0d {busy,done,audio,gain,nsd} actual=%b required=%b", cyc, act_v, exp_v);
      end
   end

   task automatic chk(input string name, input int act, input int exp_val);
      checks++;
      if (act !== exp_val) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp_val);
      end
   endtask

   // Waits (bounded) for busy, then counts busy cycles, done pulses and audio rising edges.
   task automatic measure(input string name, output int len, output int dones, output int rises,
                          output int done_pos);
      int   guard;
      logic prev_a;
      len = 0; dones = 0; rises = 0; done_pos = -1; guard = 0; prev_a = 1'b0;
      while (!busy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({name, "_busy_rise"}, int'(busy), 1);
      while (busy && len < 20000) begin
         len++;
         if (done) begin
            dones++;
            done_pos = len;
         end
         if (audio && !prev_a) rises++;
         prev_a = audio;
         @(negedge clk);
      end
      $display("run %s: busy_len=%0d dones=%0d rises=%0d done_pos=%0d", name, len, dones, rises, done_pos);
   endtask

   task automatic idle_gap(output int gap);
      gap = 0;
      while (!busy && gap < 20) begin
         gap++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len, dones, rises, dpos, gap;
      rst = 1'b1; req = 1'b0; sound_id = 2'd0;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_audio", int'(audio), 0);
      chk("reset_nsd", int'(notshutdown), 0);
      chk("reset_gain", int'(gain), 1);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of id 3, second note (E5) while audio is high.
      req = 1'b1; sound_id = 2'd3;
      @(negedge clk);
      req = 1'b0;
      chk("accept_busy", int'(busy), 1);
      chk("accept_nsd", int'(notshutdown), 1);
      repeat (1399) @(negedge clk);
      chk("pre_reset_audio", int'(audio), 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_audio", int'(audio), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_nsd", int'(notshutdown), 0);
      chk("async_gain", int'(gain), 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("txn reset_mid_play done");

      // id 3 from scratch after the reset.
      req = 1'b1; sound_id = 2'd3;
      fork begin @(negedge clk); req = 1'b0; end join_none
      measure("id3", len, dones, rises, dpos);
      chk("id3_len", len, 4001);
      chk("id3_dones", dones, 1);
      chk("id3_rises", rises, 8);
      chk("id3_done_pos", dpos, 4001);
      repeat (3) @(negedge clk);

      // id 0 single pulse.
      req = 1'b1; sound_id = 2'd0;
      fork begin @(negedge clk); req = 1'b0; end join_none
      measure("id0", len, dones, rises, dpos);
      chk("id0_len", len, 1001);
      chk("id0_dones", dones, 1);
      chk("id0_rises", rises, 3);
      chk("id0_done_pos", dpos, 1001);
      repeat (3) @(negedge clk);

      // id 1 with req held and sound_id switched to 3 mid-play.
      req = 1'b1; sound_id = 2'd1;
      fork begin repeat (500) @(negedge clk); sound_id = 2'd3; end join_none
      measure("id1_held", len, dones, rises, dpos);
      chk("id1_len", len, 3001);
      chk("id1_rises", rises, 5);
      chk("id1_dones", dones, 1);
      idle_gap(gap);
      chk("id1_gap", gap, 1);
      req = 1'b0;
      measure("id3_b2b", len, dones, rises, dpos);
      chk("id3_b2b_len", len, 4001);
      chk("id3_b2b_rises", rises, 8);
      repeat (3) @(negedge clk);

      // id 2 with req held for 6000 cycles.
      req = 1'b1; sound_id = 2'd2;
      fork begin repeat (6000) @(negedge clk); req = 1'b0; end join_none
`ifdef TONE_SEQ_REPEAT_EN
      measure("id2_repeat", len, dones, rises, dpos);
      chk("id2_rep_len", len, 8001);
      chk("id2_rep_dones", dones, 1);
      chk("id2_rep_rises", rises, 12);
      chk("id2_rep_done_pos", dpos, 8001);
`else
      measure("id2_once", len, dones, rises, dpos);
      chk("id2_len", len, 4001);
      chk("id2_dones", dones, 1);
      chk("id2_rises", rises, 6);
      idle_gap(gap);
      chk("id2_gap", gap, 1);
      measure("id2_again", len, dones, rises, dpos);
      chk("id2_again_len", len, 4001);
      chk("id2_again_dones", dones, 1);
`endif
      repeat (3) @(negedge clk);
      chk("final_idle_busy", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays short multi-note square-wave sequences on the board's mono audio amplifier in response to one-shot sound requests from the game controller. It accepts a sound request on a req/busy handshake, steps through a fixed per-sound note ROM, and drives the amplifier's `audio`, `gain` and `notshutdown` pins. It pulses `done` when the sequence finishes.

## Interface
- `NOTE_TICKS`, 12_500_000: clock cycles per note (125 ms at 100 MHz).
- `TONE_SHIFT`, 0: right shift applied to ROM half-periods (simulation speed-up).
- `HP_W`, 18: width of the half-period counter.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  sound request; sampled only in IDLE.
- `sound_id`  in  2  0 = push, 1 = win round, 2 = speed round, 3 = win game.
- `busy`  out  1  high from the cycle after acceptance until return to IDLE.
- `done`  out  1  one-cycle pulse at the end of a sequence.
- `audio`  out  1  square-wave output to the amplifier.
- `gain`  out  1  constant 1 (6 dB).
- `notshutdown`  out  1  amplifier enable; high only in PLAY.

## Operation
- Note half-periods, in clock cycles before `TONE_SHIFT`:
  - C5 = 95602
  - E5 = 75873
  - G5 = 63776
  - C6 = 47755
  - The applied half-period is the ROM value >> `TONE_SHIFT`.
- Sequences, each with an explicit length:
  - id 0: C6 (length 1).
  - id 1: C5, E5, G5 (length 3).
  - id 2: G5, C5, G5, C5 (length 4).
  - id 3: C5, E5, G5, C6 (length 4).
- FSM states are IDLE, PLAY and FINISH.
- IDLE:
  - When `req`=1, latch `sound_id`, clear note index, note counter and half-period counter, set `audio`=0, then go to PLAY.
  - When `req`=0, stay in IDLE.
- PLAY:
  - The half-period counter increments every cycle. When it reaches half-period−1, `audio` toggles and the counter clears.
  - The note counter increments every cycle. When it reaches `NOTE_TICKS`−1:
    - If this is not the last note: increment the note index, clear both counters, set `audio`=0, stay in PLAY.
    - If this is the last note: go to FINISH.
- FINISH lasts one cycle with `done`=1, `busy`=1, `audio`=0 and `notshutdown`=0, then goes to IDLE.
- Outputs per state:
  - IDLE: `audio`=0, `notshutdown`=0, `busy`=0, `done`=0.
  - PLAY: `notshutdown`=1, `busy`=1.
  - `gain`=1 always, including in reset.
- Reset values: state IDLE, and all outputs 0 except `gain`=1.
- `req` and `sound_id` are ignored while `busy`=1. There is no queueing.
- Reset mid-sequence: outputs go to reset values immediately (asynchronous), and the latched id is discarded.

## Timing
- Acceptance: `req` high at rising edge N in IDLE puts the block in PLAY after edge N. `busy` and `notshutdown` are high from cycle N+1.
- First `audio` rising edge comes HP cycles after entering PLAY (HP = shifted half-period). Period is 2·HP cycles, 50 % duty.
- Each note lasts exactly `NOTE_TICKS` cycles. `audio` phase restarts at 0 on every note boundary.
- A sequence of L notes gives L·`NOTE_TICKS` cycles in PLAY, then one FINISH cycle. `busy` falls L·`NOTE_TICKS`+1 cycles after it rose.
- `req` held high through FINISH is accepted on the first IDLE cycle, giving one idle cycle between back-to-back sequences.
- Counter widths:
  - Note counter: `$clog2(NOTE_TICKS)` bits.
  - Half-period counter: `HP_W` bits.
  - `HP_W` must cover 95602 (17 bits minimum).

## Configuration
- `TONE_SEQ_REPEAT_EN`:
  - Defined: on the last note of id 2, if `req` is high at the final tick, the note index wraps to 0 and PLAY continues without FINISH or `done`. The sequence repeats while `req` stays high and stops at the end of the first pass where `req` is low at the final tick.
  - Not defined: every id plays once; `req` is not sampled in PLAY.

## Test plan
- Test-plan parameters: `TONE_SHIFT`=8 and `NOTE_TICKS`=1000. Shifted half-periods are C5 = 373, E5 = 296, G5 = 249, C6 = 186.
1. Reset mid-PLAY of id 3 → same cycle: `audio`=0, `busy`=0, `notshutdown`=0, `gain`=1. Next `req` restarts from note 0.
2. `req` pulse, `sound_id`=0 → `audio` toggles every 186 cycles for 1000 cycles; `done` pulses at cycle 1001; `busy` high for 1001 cycles.
3. `sound_id`=3 → four notes with toggle intervals 373, 296, 249, 186, each 1000 cycles; `audio` is 0 at each note boundary; exactly one `done` pulse.
4. `req` held high during id 1 with `sound_id` changed to 3 mid-play → 3 notes (C5, E5, G5) play; then id 3 is accepted in the first IDLE cycle after FINISH.
5. With `TONE_SEQ_REPEAT_EN`, id 2 and `req` held for 6000 cycles → sequence G5, C5, G5, C5, G5, C5, G5, C5 with no intermediate `done`; a single `done` pulse after 8000 PLAY cycles.
6. Without `TONE_SEQ_REPEAT_EN`, the same stimulus as 5 → `done` after 4000 cycles; re-accepted on the next IDLE cycle with one idle cycle between runs.
